spi_flash_fetch_ctrl: RTL

//  Upstream sequencer for spi_master: turns CPU instruction/data read requests into SPI flash READ transactions.

---
 rtl/spi_flash_fetch_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/spi_flash_fetch_ctrl.sv
// spi_flash_fetch_ctrl: turns CPU read requests into SPI flash READ transactions,
// keeping sequential instruction fetches open as a continued stream.
module spi_flash_fetch_ctrl #(
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         TIMEOUT  = 8191
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic        req_is_instr,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        spi_start,
    output logic        spi_stop,
    output logic        spi_cont,
    output logic        spi_write_enable,
    output logic        spi_is_instr,
    output logic [31:0] spi_cmd_addr,
    output logic [5:0]  spi_data_len,
    output logic [31:0] spi_data_in,
    input  logic [31:0] spi_data_out,
    input  logic        spi_done
);
    localparam logic [1:0] RST_STOP = 2'd0, IDLE = 2'd1, START = 2'd2, WAIT = 2'd3;
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [1:0]    state;
    logic          stream_ok;
    logic [23:0]   next_addr;
    logic          spi_done_q;
    logic [TW-1:0] timer;
    logic          done_edge;
    logic [22:0]   inc;
    assign done_edge        = spi_done && !spi_done_q;
    // Word address of the current transaction plus one; bit 22 flags a wrap past 0xFFFFFC.
    assign inc              = {1'b0, spi_cmd_addr[23:2]} + 23'd1;
    assign req_ready        = state == IDLE;
    assign spi_write_enable = 1'b0;
    assign spi_data_len     = 6'd32;
    assign spi_data_in      = 32'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST_STOP;
            stream_ok    <= 1'b0;
            next_addr    <= 24'd0;
            spi_done_q   <= 1'b0;
            timer        <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            spi_start    <= 1'b0;
            spi_stop     <= 1'b0;
            spi_cont     <= 1'b0;
            spi_is_instr <= 1'b0;
            spi_cmd_addr <= {READ_CMD, 24'h0};
        end else begin
            spi_done_q <= spi_done;
            rsp_valid  <= 1'b0;
            spi_start  <= 1'b0;
            spi_stop   <= 1'b0;
            spi_cont   <= 1'b0;
            timer      <= '0;
            case (state)
                RST_STOP: begin
                    spi_stop <= 1'b1;
                    state    <= IDLE;
                end
                IDLE: if (req_valid) begin
                    spi_cmd_addr <= {READ_CMD, req_addr[23:2], 2'b00};
                    spi_is_instr <= req_is_instr;
                    if (req_is_instr && stream_ok && req_addr[23:2] == next_addr[23:2]) begin
                        spi_cont <= 1'b1;
                        state    <= WAIT;
                    end else if (stream_ok) begin
                        spi_stop  <= 1'b1;
                        stream_ok <= 1'b0;
                        state     <= START;
                    end else begin
                        spi_start <= 1'b1;
                        state     <= WAIT;
                    end
                end
                START: begin
                    spi_start <= 1'b1;
                    state     <= WAIT;
                end
                default: if (done_edge) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= {spi_data_out[7:0], spi_data_out[15:8], spi_data_out[23:16], spi_data_out[31:24]};
                    rsp_err   <= 1'b0;
                    stream_ok <= spi_is_instr && !inc[22];
                    next_addr <= spi_is_instr ? {inc[21:0], 2'b00} : next_addr;
                    state     <= IDLE;
                end else if (timer == TW'(TIMEOUT)) begin
                    spi_stop  <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'd0;
                    stream_ok <= 1'b0;
                    state     <= IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
            endcase
        end
    end
endmodule
